// File: rtl/inst_mem_access.sv
// Memory-access pipeline stage: passes non-memory ops straight to writeback and
// runs LD/ST through a request/ack handshake with a bounded wait.
module inst_mem_access #(
    parameter logic [3:0] LD_OP   = 4'b1010,
    parameter logic [3:0] ST_OP   = 4'b1011,
    parameter int         TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_ctrl,
    input  logic        valid_ctrl,
    input  logic [3:0]  opcode,
    input  logic [15:0] alu_result,
    input  logic [15:0] store_data,
    input  logic [2:0]  rc_addr,
    input  logic        rf_w_en,
    output logic        dm_req,
    output logic        dm_we,
    output logic [15:0] dm_addr,
    output logic [15:0] dm_wdata,
    input  logic [15:0] dm_rdata,
    input  logic        dm_ack,
    output logic        busy,
    output logic        wb_valid,
    output logic [2:0]  wb_rc_addr,
    output logic [15:0] wb_rc_data,
    output logic        wb_rf_w_en,
    output logic [3:0]  wb_opcode,
    output logic        err
);
    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

    state_t      state_reg;
    logic [3:0]  wait_cnt_reg;
    logic [3:0]  op_reg;
    logic [2:0]  rc_reg;
    logic        wen_reg;

    logic        accept;
    logic        is_mem_op;
    logic [3:0]  wait_cnt_next;

    assign accept        = (state_reg == IDLE) && en_ctrl && valid_ctrl;
    assign is_mem_op     = (opcode == LD_OP) || (opcode == ST_OP);
    assign wait_cnt_next = wait_cnt_reg + 4'd1;
    assign busy          = (state_reg == ACC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 4'd0;
            op_reg       <= 4'd0;
            rc_reg       <= 3'd0;
            wen_reg      <= 1'b0;
            dm_req       <= 1'b0;
            dm_we        <= 1'b0;
            dm_addr      <= 16'd0;
            dm_wdata     <= 16'd0;
            wb_valid     <= 1'b0;
            wb_rc_addr   <= 3'd0;
            wb_rc_data   <= 16'd0;
            wb_rf_w_en   <= 1'b0;
            wb_opcode    <= 4'd0;
            err          <= 1'b0;
        end else begin
            // Pulses and the write enable fall back to 0 unless set below.
            wb_valid   <= 1'b0;
            wb_rf_w_en <= 1'b0;
            err        <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept && is_mem_op) begin
                        state_reg    <= ACC;
                        wait_cnt_reg <= 4'd0;
                        op_reg       <= opcode;
                        rc_reg       <= rc_addr;
                        wen_reg      <= rf_w_en;
                        dm_req       <= 1'b1;
                        dm_we        <= (opcode == ST_OP);
                        dm_addr      <= alu_result;
                        dm_wdata     <= store_data;
                    end else if (accept) begin
                        wb_valid   <= 1'b1;
                        wb_opcode  <= opcode;
                        wb_rc_addr <= rc_addr;
                        wb_rc_data <= alu_result;
                        wb_rf_w_en <= rf_w_en;
                    end
                end
                ACC: begin
                    // An ack on the final wait cycle still completes normally.
                    if (dm_ack) begin
                        state_reg  <= IDLE;
                        dm_req     <= 1'b0;
                        dm_we      <= 1'b0;
                        wb_valid   <= 1'b1;
                        wb_opcode  <= op_reg;
                        wb_rc_addr <= rc_reg;
                        if (op_reg == ST_OP) begin
                            wb_rc_data <= 16'd0;
                            wb_rf_w_en <= 1'b0;
                        end else begin
                            wb_rc_data <= dm_rdata;
                            wb_rf_w_en <= wen_reg;
                        end
                    end else if (wait_cnt_next == TIMEOUT_CNT) begin
                        state_reg    <= IDLE;
                        wait_cnt_reg <= wait_cnt_next;
                        dm_req       <= 1'b0;
                        dm_we        <= 1'b0;
                        err          <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_next;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
